interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 93 +++++++++
 tb/tb_interval_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// interval_timer: NCH independent down-counting interval timers, each with its own period and one-shot/periodic mode.
// Optional feature macro INTERVAL_TIMER_IRQ_EN adds sticky per-channel pending bits, irq_clr and a combined irq.
module interval_timer #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 16,
    parameter int DEF_PERIOD = 9,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
`ifdef INTERVAL_TIMER_IRQ_EN
   ,input  logic [NCH-1:0]   irq_clr,
    output logic             irq
`endif
);

    logic cfg_ok;
    assign cfg_ok = cfg_we && (32'(cfg_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] period_q;
        logic [WIDTH-1:0] count_q;
        logic             oneshot_q;
        logic             busy_q;
        logic             tick_q;
        logic             hit;
        logic [WIDTH-1:0] load_val;

        // A write landing on the same edge as a load is seen by that load.
        assign hit      = cfg_ok && (cfg_ch == CHW'(i));
        assign load_val = hit ? cfg_period : period_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                period_q  <= WIDTH'(DEF_PERIOD);
                oneshot_q <= 1'b0;
                count_q   <= '0;
                busy_q    <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                if (hit) begin
                    period_q  <= cfg_period;
                    oneshot_q <= cfg_oneshot;
                end
                tick_q <= 1'b0;
                if (stop[i]) begin
                    busy_q <= 1'b0;
                end else if (start[i]) begin
                    busy_q  <= 1'b1;
                    count_q <= load_val;
                end else if (busy_q) begin
                    if (count_q != '0) begin
                        count_q <= count_q - WIDTH'(1);
                    end else begin
                        tick_q <= 1'b1;
                        if (oneshot_q) busy_q  <= 1'b0;
                        else           count_q <= load_val;
                    end
                end
            end
        end

        assign tick[i] = tick_q;
        assign busy[i] = busy_q;
    end

`ifdef INTERVAL_TIMER_IRQ_EN
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] pending_d;

    // Set wins over a coincident clear so an expiry is never lost.
    assign pending_d = (pending_q & ~irq_clr) | tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            irq       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq       <= |pending_d;
        end
    end
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: expected tick events are queued as stimulus is driven and popped as ticks appear.
// Also drives a 5-channel instance so an out-of-range channel index is representable.
module tb_interval_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_oneshot;
    logic [3:0]  start, stop, tick, busy;

    logic        cfg_we_b;
    logic [2:0]  cfg_ch_b;
    logic [15:0] cfg_period_b;
    logic        cfg_oneshot_b;
    logic [4:0]  start_b, stop_b, tick_b, busy_b;

`ifdef INTERVAL_TIMER_IRQ_EN
    logic [3:0]  irq_clr;
    logic        irq;
    logic [4:0]  irq_clr_b;
    logic        irq_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int s, r;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;
    ev_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interval_timer #(.NCH(4), .WIDTH(16), .DEF_PERIOD(9)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
        .start(start), .stop(stop), .tick(tick), .busy(busy)
`ifdef INTERVAL_TIMER_IRQ_EN
       ,.irq_clr(irq_clr), .irq(irq)
`endif
    );

    interval_timer #(.NCH(5), .WIDTH(16), .DEF_PERIOD(9)) u_b (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
        .cfg_period(cfg_period_b), .cfg_oneshot(cfg_oneshot_b),
        .start(start_b), .stop(stop_b), .tick(tick_b), .busy(busy_b)
`ifdef INTERVAL_TIMER_IRQ_EN
       ,.irq_clr(irq_clr_b), .irq(irq_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int c);
        ev_t e;
        e.ch  = ch;
        e.cyc = c;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (tick[c] === 1'b1) begin
                if (expq.size() == 0) begin
                    check("unexpected_tick", 32'(tick[c]), 32'd0);
                end else begin
                    ev_t e;
                    e = expq.pop_front();
                    check("tick_ch", 32'(c), 32'(e.ch));
                    check("tick_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
        start = '0; stop = '0;
        cfg_we_b = 1'b0; cfg_ch_b = '0; cfg_period_b = '0; cfg_oneshot_b = 1'b0;
        start_b = '0; stop_b = '0;
`ifdef INTERVAL_TIMER_IRQ_EN
        irq_clr = '0; irq_clr_b = '0;
`endif
        cycles(2);
        rst_n = 1'b1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef INTERVAL_TIMER_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        // ch0 periodic with the default period: ticks at +10, +20, +30
        s = cyc + 1;
        push(0, s + 10); push(0, s + 20); push(0, s + 30);
        start[0] = 1'b1; cycles(1); start[0] = 1'b0;
        check("busy0_start", 32'(busy[0]), 32'd1);
        repeat (34) begin
            cycles(1);
            check("busy0_run", 32'(busy[0]), 32'd1);
        end
        stop[0] = 1'b1; cycles(1); stop[0] = 1'b0;
        check("busy0_stop", 32'(busy[0]), 32'd0);

        // ch1 one-shot P=3: single tick 4 cycles after start
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd3; cfg_oneshot = 1'b1;
        cycles(1);
        cfg_we = 1'b0;
        s = cyc + 1;
        push(1, s + 4);
        start[1] = 1'b1; cycles(1); start[1] = 1'b0;
        cycles(3);
        check("busy1_counting", 32'(busy[1]), 32'd1);
        cycles(1);
        check("tick1_oneshot", 32'(tick[1]), 32'd1);
        check("busy1_done", 32'(busy[1]), 32'd0);
        cycles(50);

        // ch2 start and stop together: stop wins
        start[2] = 1'b1; stop[2] = 1'b1; cycles(1); start[2] = 1'b0; stop[2] = 1'b0;
        check("busy2_stopwins", 32'(busy[2]), 32'd0);
        cycles(15);
        // ch2 restarted when count reaches 5
        s = cyc + 1;
        start[2] = 1'b1; cycles(1); start[2] = 1'b0;
        cycles(4);
        r = cyc + 1;
        push(2, r + 10);
        start[2] = 1'b1; cycles(1); start[2] = 1'b0;
        check("busy2_restart", 32'(busy[2]), 32'd1);
        cycles(10);
        check("tick2_restart", 32'(tick[2]), 32'd1);
        stop[2] = 1'b1; cycles(1); stop[2] = 1'b0;
        check("busy2_final", 32'(busy[2]), 32'd0);

        // reset while ch0 count is 2
        start[0] = 1'b1; cycles(1); start[0] = 1'b0;
        cycles(7);
        rst_n = 1'b0; cycles(1); rst_n = 1'b1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_tick", 32'(tick), 32'd0);
        cycles(20);
        s = cyc + 1;
        push(0, s + 10);
        start[0] = 1'b1; cycles(1); start[0] = 1'b0;
        cycles(10);
        check("tick0_defperiod", 32'(tick[0]), 32'd1);
        stop[0] = 1'b1; cycles(1); stop[0] = 1'b0;

        // out-of-range channel writes on the 5-channel instance are ignored
        cfg_we_b = 1'b1; cfg_ch_b = 3'd5; cfg_period_b = 16'd2; cfg_oneshot_b = 1'b1;
        cycles(1);
        cfg_ch_b = 3'd7;
        cycles(1);
        cfg_we_b = 1'b0;
        s = cyc + 1;
        start_b = '1; cycles(1); start_b = '0;
        cycles(3);
        check("oor_no_early_tick", 32'(tick_b), 32'd0);
        cycles(6);
        check("oor_tick_s9", 32'(tick_b), 32'd0);
        cycles(1);
        check("oor_tick_s10", 32'(tick_b), 32'h1f);
        check("oor_busy_periodic", 32'(busy_b), 32'h1f);
        stop_b = '1; cycles(1); stop_b = '0;

        // ch3 P=0 periodic: tick every cycle
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd0; cfg_oneshot = 1'b0;
        cycles(1);
        cfg_we = 1'b0;
        s = cyc + 1;
        for (int k = 1; k <= 6; k++) push(3, s + k);
        start[3] = 1'b1; cycles(1); start[3] = 1'b0;
        cycles(6);
        stop[3] = 1'b1; cycles(1); stop[3] = 1'b0;
        check("busy3_p0_stop", 32'(busy[3]), 32'd0);

        // ch3 P=9 running, rewritten to P=4: old period completes, then every 5
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd9;
        cycles(1);
        cfg_we = 1'b0;
        s = cyc + 1;
        push(3, s + 10); push(3, s + 15); push(3, s + 20);
        start[3] = 1'b1; cycles(1); start[3] = 1'b0;
        cycles(2);
        cfg_we = 1'b1; cfg_period = 16'd4;
        cycles(1);
        cfg_we = 1'b0;
        cycles(17);
        stop[3] = 1'b1; cycles(1); stop[3] = 1'b0;
        check("busy3_final", 32'(busy[3]), 32'd0);

`ifdef INTERVAL_TIMER_IRQ_EN
        // ch1 back to default period after reset; exercise pending/irq
        s = cyc + 1;
        push(1, s + 10); push(1, s + 20);
        start[1] = 1'b1; cycles(1); start[1] = 1'b0;
        cycles(10);
        check("irq_during_tick", 32'(irq), 32'd0);
        cycles(1);
        check("irq_set", 32'(irq), 32'd1);
        irq_clr[1] = 1'b1; cycles(1); irq_clr[1] = 1'b0;
        check("irq_cleared", 32'(irq), 32'd0);
        cycles(8);
        check("tick1_irq", 32'(tick[1]), 32'd1);
        irq_clr[1] = 1'b1; cycles(1); irq_clr[1] = 1'b0;
        check("irq_set_wins", 32'(irq), 32'd1);
        cycles(1);
        check("irq_sticky", 32'(irq), 32'd1);
        stop[1] = 1'b1; cycles(1); stop[1] = 1'b0;
        irq_clr = '1; cycles(1); irq_clr = '0;
        check("irq_final_clear", 32'(irq), 32'd0);
`endif

        cycles(5);
        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
